// File: rtl/register_file.sv
// 32 x 32 general-purpose register file: two combinational read ports, one
// synchronous write port, register 0 reads as zero regardless of contents.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic [ADDR_WIDTH-1:0] A1,
    input  logic [ADDR_WIDTH-1:0] A2,
    input  logic [ADDR_WIDTH-1:0] A3,
    input  logic                  WE3,
    input  logic [DATA_WIDTH-1:0] WD3,
    output logic [DATA_WIDTH-1:0] RD1,
    output logic [DATA_WIDTH-1:0] RD2
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (WE3 && (A3 != '0)) begin
            regs[A3] <= WD3;
        end
    end

    // Address 0 is masked on read so it is zero even without a reset.
    always_comb begin
        RD1 = (A1 == '0) ? '0 : regs[A1];
        RD2 = (A2 == '0) ? '0 : regs[A2];
    end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus queues expected read values,
// a monitor samples RD1/RD2 on each sample strobe and compares.
module tb_register_file;

    logic        CLK;
    logic        RST_N;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [4:0]  A3;
    logic        WE3;
    logic [31:0] WD3;
    logic [31:0] RD1;
    logic [31:0] RD2;

    logic clk_en;

    typedef struct {
        string       tag;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    exp_t sb[$];
    event sample_ev;
    int   vectors;
    int   miscompares;

    register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .A1   (A1),
        .A2   (A2),
        .A3   (A3),
        .WE3  (WE3),
        .WD3  (WD3),
        .RD1  (RD1),
        .RD2  (RD2)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = clk_en ? ~CLK : 1'b0;
    end

    // Monitor: pops one expectation per strobe and compares both ports.
    initial begin
        exp_t e;
        vectors     = 0;
        miscompares = 0;
        forever begin
            @(sample_ev);
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_sample: strobe with empty scoreboard at %0t", $time);
            end else begin
                e = sb.pop_front();
                vectors++;
                if (RD1 !== e.e1) begin
                    miscompares++;
                    $display("FAIL %s RD1 (A1=%0d): got %h, expected %h", e.tag, e.a1, RD1, e.e1);
                end
                if (RD2 !== e.e2) begin
                    miscompares++;
                    $display("FAIL %s RD2 (A2=%0d): got %h, expected %h", e.tag, e.a2, RD2, e.e2);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [4:0] a1, input logic [4:0] a2,
                         input logic [31:0] e1, input logic [31:0] e2);
        exp_t e;
        A1 = a1;
        A2 = a2;
        #1;
        e = '{tag, a1, a2, e1, e2};
        sb.push_back(e);
        ->sample_ev;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic write(input logic [4:0] addr, input logic [31:0] data);
        A3  = addr;
        WD3 = data;
        WE3 = 1'b1;
        tick();
        WE3 = 1'b0;
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] w;
        clk_en = 1'b0;
        RST_N  = 1'b1;
        A1 = '0; A2 = '0; A3 = '0; WE3 = 1'b0; WD3 = '0;

        // Asynchronous reset with the clock stopped
        #3 RST_N = 1'b0;
        #1;
        for (int i = 0; i < 32; i++) begin
            check("reset_held", 5'(i), 5'(31 - i), 32'h0, 32'h0);
        end
        RST_N  = 1'b1;
        clk_en = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 32; i++) begin
            check("after_release", 5'(i), 5'(i), 32'h0, 32'h0);
        end

        // Sequential writes and reads
        tick();
        write(5'd1, 32'h0000_004D);
        A3 = 5'd3; WD3 = 32'h0000_004D; WE3 = 1'b1;
        tick();
        check("seq_rd_reg1", 5'd3, 5'd1, 32'h0000_004D, 32'h0000_004D);
        A3 = 5'd6; WD3 = 32'd666; WE3 = 1'b1;
        tick();
        WE3 = 1'b0;
        check("seq_rd_reg3", 5'd1, 5'd3, 32'h0000_004D, 32'h0000_004D);
        check("seq_rd_3_6", 5'd3, 5'd6, 32'h0000_004D, 32'h0000_029A);
        tick();
        check("seq_idle_edge", 5'd3, 5'd6, 32'h0000_004D, 32'h0000_029A);

        // Write-enable gating
        A3 = 5'd5; WD3 = 32'hDEAD_BEEF; WE3 = 1'b0;
        tick();
        check("we_gated", 5'd5, 5'd5, 32'h0, 32'h0);

        // Register 0 discards writes
        write(5'd0, 32'hFFFF_FFFF);
        check("reg0_write", 5'd0, 5'd0, 32'h0, 32'h0);

        // Same-address read during write: old value before edge, new after
        A3 = 5'd7; WD3 = 32'h1234_5678; WE3 = 1'b1;
        check("same_addr_before", 5'd7, 5'd7, 32'h0, 32'h0);
        tick();
        WE3 = 1'b0;
        check("same_addr_after", 5'd7, 5'd3, 32'h1234_5678, 32'h0000_004D);

        // Reset pulse between edges clears immediately
        RST_N = 1'b0;
        check("rst_pulse", 5'd7, 5'd3, 32'h0, 32'h0);
        RST_N = 1'b1;
        check("rst_pulse_rel", 5'd7, 5'd6, 32'h0, 32'h0);

        // Reset held across an edge overrides a pending write
        A3 = 5'd9; WD3 = 32'hA5A5_A5A5; WE3 = 1'b1;
        RST_N = 1'b0;
        tick();
        check("rst_override", 5'd9, 5'd9, 32'h0, 32'h0);
        RST_N = 1'b1;
        tick();
        WE3 = 1'b0;
        check("post_rst_write", 5'd9, 5'd7, 32'hA5A5_A5A5, 32'h0);

        // Full sweep
        for (int i = 1; i < 32; i++) begin
            write(5'(i), 32'(i) * 32'h0101_0101);
        end
        for (int i = 0; i < 32; i++) begin
            v = 32'(i) * 32'h0101_0101;
            w = 32'(31 - i) * 32'h0101_0101;
            check("sweep", 5'(i), 5'(31 - i), v, w);
        end
        check("sweep_r31", 5'd31, 5'd16, 32'h1F1F_1F1F, 32'h1010_1010);

        // Drain scoreboard with a bounded wait
        for (int k = 0; k < 100 && sb.size() != 0; k++) #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
